// File: rtl/inst_fifo_pkg.sv
// Shared CPU front-end definitions: queue depth and the fetch/decode entry format.
package cpu_defs;

  localparam int INST_FIFO_DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } inst_entry_t;

endpackage

// File: rtl/inst_fifo_if.sv
// Fetch/decode side bundle of the instruction queue: push lanes, pop count and head window.
interface inst_fifo_if
  import cpu_defs::*;
#(
  parameter int CNT_W = $clog2(INST_FIFO_DEPTH) + 1
);
  logic             flush;
  logic             push_en;
  logic             push_ok1;
  logic             push_ok2;
  logic [31:0]      push_pc;
  logic [31:0]      push_inst1;
  logic [31:0]      push_inst2;
  logic [1:0]       pop_cnt;
  logic             out_valid1;
  logic             out_valid2;
  logic [31:0]      out_inst1;
  logic [31:0]      out_inst2;
  logic [31:0]      out_pc1;
  logic [31:0]      out_pc2;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, push_en, push_ok1, push_ok2, push_pc, push_inst1, push_inst2, pop_cnt,
    input  out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2, full, empty, count
  );

  modport slave (
    input  flush, push_en, push_ok1, push_ok2, push_pc, push_inst1, push_inst2, pop_cnt,
    output out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2, full, empty, count
  );
endinterface

// File: rtl/inst_fifo.sv
// Dual-issue instruction queue: up to two pushes and two pops per cycle, head window
// of two entries presented combinationally to decode.
module inst_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = INST_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic       clk,
  input logic       resetn,
  inst_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] cnt;
  inst_entry_t      mem [DEPTH];

  logic             full_int;
  logic [1:0]       n_push;
  logic [1:0]       pop_req;
  logic [1:0]       n_pop;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  inst_entry_t      rd1, rd2;

  assign full_int = cnt >= CNT_W'(DEPTH - 1);
  assign head_p1  = head + PTR_W'(1);
  assign tail_p1  = tail + PTR_W'(1);

  always_comb begin
    n_push = '0;
    if (bus.push_en && bus.push_ok1 && !full_int)
      n_push = bus.push_ok2 ? 2'd2 : 2'd1;
  end

  // Decode can retire at most two per cycle, and never more than are present.
  always_comb begin
    pop_req = (bus.pop_cnt == 2'd3) ? 2'd2 : bus.pop_cnt;
    n_pop   = pop_req;
    if (CNT_W'(pop_req) > cnt)
      n_pop = cnt[1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PTR_W'(n_pop);
      tail <= tail + PTR_W'(n_push);
      cnt  <= cnt + CNT_W'(n_push) - CNT_W'(n_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.flush && n_push != 2'd0)
      mem[tail] <= '{pc: bus.push_pc, inst: bus.push_inst1};
    if (!bus.flush && n_push == 2'd2)
      mem[tail_p1] <= '{pc: bus.push_pc + 32'd4, inst: bus.push_inst2};
  end

  assign rd1 = mem[head];
  assign rd2 = mem[head_p1];

  assign bus.out_valid1 = cnt >= CNT_W'(1);
  assign bus.out_valid2 = cnt >= CNT_W'(2);
  assign bus.out_inst1  = bus.out_valid1 ? rd1.inst : '0;
  assign bus.out_pc1    = bus.out_valid1 ? rd1.pc   : '0;
  assign bus.out_inst2  = bus.out_valid2 ? rd2.inst : '0;
  assign bus.out_pc2    = bus.out_valid2 ? rd2.pc   : '0;
  assign bus.full       = full_int;
  assign bus.empty      = cnt == '0;
  assign bus.count      = cnt;
endmodule

// File: tb/tb_inst_fifo.sv
// Directed bench for inst_fifo: hand-computed expectations checked with immediate assertions.
module tb_inst_fifo;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inst_fifo_if #(.CNT_W(5)) bus ();

  inst_fifo #(.DEPTH(16), .CNT_W(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.flush      = 1'b0;
    bus.push_en    = 1'b0;
    bus.push_ok1   = 1'b0;
    bus.push_ok2   = 1'b0;
    bus.push_pc    = '0;
    bus.push_inst1 = '0;
    bus.push_inst2 = '0;
    bus.pop_cnt    = '0;
  endtask

  // Apply one cycle of stimulus, clock it, then return to idle 1 time unit after the edge.
  task automatic cyc(input logic en, input logic ok1, input logic ok2, input logic [31:0] pc,
                     input logic [31:0] i1, input logic [31:0] i2, input logic [1:0] pop,
                     input logic fl);
    bus.flush      = fl;
    bus.push_en    = en;
    bus.push_ok1   = ok1;
    bus.push_ok2   = ok2;
    bus.push_pc    = pc;
    bus.push_inst1 = i1;
    bus.push_inst2 = i2;
    bus.pop_cnt    = pop;
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_valid1", 32'(bus.out_valid1), 32'd0);
    resetn = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Dual push then dual pop
    cyc(1, 1, 1, 32'hBFC00000, 32'h24080001, 32'h24090002, 2'd0, 0);
    check("dual_pc1", bus.out_pc1, 32'hBFC00000);
    check("dual_pc2", bus.out_pc2, 32'hBFC00004);
    check("dual_inst1", bus.out_inst1, 32'h24080001);
    check("dual_inst2", bus.out_inst2, 32'h24090002);
    check("dual_count", 32'(bus.count), 32'd2);
    cyc(0, 0, 0, 0, 0, 0, 2'd2, 0);
    check("pop2_empty", 32'(bus.empty), 32'd1);
    check("pop2_pc1_gated", bus.out_pc1, 32'd0);

    // Partial pushes
    cyc(1, 1, 0, 32'h00000100, 32'h0000000A, 32'h0000000B, 2'd0, 0);
    check("ok1_count", 32'(bus.count), 32'd1);
    cyc(1, 0, 1, 32'h00000200, 32'h0000000C, 32'h0000000D, 2'd0, 0);
    check("ok2only_count", 32'(bus.count), 32'd1);
    check("ok2only_pc1", bus.out_pc1, 32'h00000100);
    check("ok2only_valid2", 32'(bus.out_valid2), 32'd0);
    check("ok2only_pc2_gated", bus.out_pc2, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 2'd1, 0);
    check("pop1_count", 32'(bus.count), 32'd0);

    // Pop against an empty queue does not consume the same-cycle push
    cyc(1, 1, 0, 32'h00000300, 32'h0000000E, 32'h0, 2'd1, 0);
    check("single_count", 32'(bus.count), 32'd1);
    check("single_pc1", bus.out_pc1, 32'h00000300);
    cyc(0, 0, 0, 0, 0, 0, 2'd3, 0);
    check("pop3_clamp_count", 32'(bus.count), 32'd0);

    // Fill: entries i = 0..14 with pc 0x1000+4i, inst 0x100+i
    for (int k = 0; k < 7; k++)
      cyc(1, 1, 1, 32'h1000 + 32'(8 * k), 32'h100 + 32'(2 * k), 32'h101 + 32'(2 * k), 2'd0, 0);
    check("fill14_count", 32'(bus.count), 32'd14);
    check("fill14_full", 32'(bus.full), 32'd0);
    cyc(1, 1, 0, 32'h1038, 32'h10E, 32'h0, 2'd0, 0);
    check("fill15_count", 32'(bus.count), 32'd15);
    check("fill15_full", 32'(bus.full), 32'd1);
    cyc(1, 1, 1, 32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 2'd0, 0);
    check("full_ignore_count", 32'(bus.count), 32'd15);
    check("full_head_pc", bus.out_pc1, 32'h1000);
    cyc(1, 1, 1, 32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 2'd1, 0);
    check("full_pushpop_count", 32'(bus.count), 32'd14);

    // Drain one per cycle across the pointer wrap
    for (int i = 1; i <= 14; i++) begin
      check("drain_pc1", bus.out_pc1, 32'h1000 + 32'(4 * i));
      check("drain_inst1", bus.out_inst1, 32'h100 + 32'(i));
      if (i < 14) check("drain_pc2", bus.out_pc2, 32'h1004 + 32'(4 * i));
      cyc(0, 0, 0, 0, 0, 0, 2'd1, 0);
    end
    check("drain_empty", 32'(bus.empty), 32'd1);

    // Push 2 / pop 1 at count 3
    cyc(1, 1, 1, 32'h2000, 32'hA0, 32'hA1, 2'd0, 0);
    cyc(1, 1, 0, 32'h2008, 32'hA2, 32'h0, 2'd0, 0);
    check("pp_count3", 32'(bus.count), 32'd3);
    cyc(1, 1, 1, 32'h200C, 32'hA3, 32'hA4, 2'd1, 0);
    check("pp_count4", 32'(bus.count), 32'd4);
    check("pp_pc1", bus.out_pc1, 32'h2004);
    check("pp_pc2", bus.out_pc2, 32'h2008);
    cyc(0, 0, 0, 0, 0, 0, 2'd2, 0);
    check("pp_pop2_pc1", bus.out_pc1, 32'h200C);
    check("pp_pop2_pc2", bus.out_pc2, 32'h2010);
    check("pp_pop2_inst2", bus.out_inst2, 32'hA4);

    // Flush beats same-cycle push and pop
    cyc(1, 1, 1, 32'h2014, 32'hA5, 32'hA6, 2'd0, 0);
    cyc(1, 1, 0, 32'h201C, 32'hA7, 32'h0, 2'd0, 0);
    check("pre_flush_count", 32'(bus.count), 32'd5);
    cyc(1, 1, 1, 32'hF000, 32'hF1, 32'hF2, 2'd2, 1);
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    check("flush_valid1", 32'(bus.out_valid1), 32'd0);
    cyc(1, 1, 1, 32'h3000, 32'hB0, 32'hB1, 2'd0, 0);
    check("post_flush_pc1", bus.out_pc1, 32'h3000);
    check("post_flush_inst2", bus.out_inst2, 32'hB1);

    // Asynchronous reset mid-cycle
    #2;
    resetn = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_empty", 32'(bus.empty), 32'd1);
    check("arst_full", 32'(bus.full), 32'd0);
    check("arst_valid1", 32'(bus.out_valid1), 32'd0);
    check("arst_valid2", 32'(bus.out_valid2), 32'd0);
    check("arst_inst1", bus.out_inst1, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc(1, 1, 0, 32'h4000, 32'hC0, 32'h0, 2'd0, 0);
    check("after_rst_count", 32'(bus.count), 32'd1);
    check("after_rst_pc1", bus.out_pc1, 32'h4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
